frame_reader: RTL

//  Scan-out end of the render pipeline. The rasterizer writes RGB565 pixels into a

---
 rtl/frame_reader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_reader
//  Purpose  : Scan-out stage of the render pipeline. Reads the display half of
//             a double-buffered RGB565 framebuffer in step with the video
//             timing, upscaling WIDTHxHEIGHT to the active raster by address
//             decimation (2**SCALE_LOG replication in both axes), expands the
//             pixel to RGB888, and swaps buffers at the first vblank line
//             under a frame_done / render_start handshake.
//  Ports    : clk_in, rst_n_in (async active-low)
//             hcount_in, vcount_in, active_draw_in, hsync_in, vsync_in : timing
//             frame_done_in    : renderer finished the write buffer (pulse)
//             rd_data_in       : BRAM data, valid 2 cycles after rd_addr_out
//             rd_addr_out      : BRAM read address (base + row*WIDTH + col)
//             clr_we_out, clr_addr_out, clr_data_out : BRAM clear port
//             write_buffer_out : buffer the renderer may write
//             render_start_out : pulse, renderer may begin the next frame
//             overrun_out      : sticky, frame_done arrived out of turn
//             red/green/blue_out, hsync/vsync/active_draw_out : video out,
//             all 4 cycles behind the timing inputs
//  Options  : CLEAR_ON_READ_EN - when defined, each framebuffer word is
//             overwritten with BG_COLOR after its last replica is read.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_reader #(
   parameter int unsigned WIDTH     = 320,
   parameter int unsigned HEIGHT    = 180,
   parameter int unsigned SCALE_LOG = 2,
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned V_ACTIVE  = 720,
   parameter logic [15:0] BG_COLOR  = 16'h0000
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        active_draw_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        frame_done_in,
   input  logic [15:0] rd_data_in,
   output logic [16:0] rd_addr_out,
   output logic        clr_we_out,
   output logic [16:0] clr_addr_out,
   output logic [15:0] clr_data_out,
   output logic        write_buffer_out,
   output logic        render_start_out,
   output logic        overrun_out,
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        active_draw_out
);

   localparam logic [16:0] C_BUF1_BASE = 17'(WIDTH * HEIGHT);

   typedef enum logic [1:0] {
      ST_INIT      = 2'd0,
      ST_RENDERING = 2'd1,
      ST_PENDING   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        disp_q, disp_d;
   logic        overrun_q, overrun_d;
   logic        render_start_q, render_start_d;

   logic [16:0] rd_addr_q;
   logic [3:0]  act_q, hs_q, vs_q;
   logic [7:0]  red_q, green_q, blue_q;

   logic [16:0] w_col, w_row, w_base, w_rd_addr;
   logic        w_rd_en, w_swap;

   // Read only inside the visible raster so the address never leaves the buffer.
   assign w_rd_en   = active_draw_in && (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
   assign w_swap    = (hcount_in == 11'd0) && (vcount_in == 10'(V_ACTIVE));
   assign w_col     = 17'(hcount_in >> SCALE_LOG);
   assign w_row     = 17'(vcount_in >> SCALE_LOG);
   assign w_base    = disp_q ? C_BUF1_BASE : 17'd0;
   // Constant multiply reduces to shift-and-add ((row<<8)+(row<<6) for 320).
   assign w_rd_addr = w_base + (w_row * 17'(WIDTH)) + w_col;

   // Buffer-swap handshake
   always_comb begin
      state_d        = state_q;
      disp_d         = disp_q;
      overrun_d      = overrun_q;
      render_start_d = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (frame_done_in) overrun_d = 1'b1;
            if (w_swap) begin
               render_start_d = 1'b1;
               state_d        = ST_RENDERING;
            end
         end
         ST_RENDERING: begin
            if (frame_done_in) begin
               // A frame finished exactly on the swap line is swapped at once.
               if (w_swap) begin
                  disp_d         = ~disp_q;
                  render_start_d = 1'b1;
               end else begin
                  state_d = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (frame_done_in) overrun_d = 1'b1;
            if (w_swap) begin
               disp_d         = ~disp_q;
               render_start_d = 1'b1;
               state_d        = ST_RENDERING;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q        <= ST_INIT;
         disp_q         <= 1'b0;
         overrun_q      <= 1'b0;
         render_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         disp_q         <= disp_d;
         overrun_q      <= overrun_d;
         render_start_q <= render_start_d;
      end
   end

   // Address register, BRAM (2 cycles), output register; timing rides a
   // 4-deep shift so it stays aligned with the colour.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rd_addr_q <= 17'd0;
         act_q     <= 4'd0;
         hs_q      <= 4'd0;
         vs_q      <= 4'd0;
         red_q     <= 8'd0;
         green_q   <= 8'd0;
         blue_q    <= 8'd0;
      end else begin
         if (w_rd_en) rd_addr_q <= w_rd_addr;
         act_q <= {act_q[2:0], active_draw_in};
         hs_q  <= {hs_q[2:0], hsync_in};
         vs_q  <= {vs_q[2:0], vsync_in};
         // act_q[2] is the active flag of the pixel whose data is on rd_data_in now.
         if (act_q[2]) begin
            red_q   <= {rd_data_in[15:11], rd_data_in[15:13]};
            green_q <= {rd_data_in[10:5],  rd_data_in[10:9]};
            blue_q  <= {rd_data_in[4:0],   rd_data_in[4:2]};
         end else begin
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
         end
      end
   end

`ifdef CLEAR_ON_READ_EN
   logic        clr_pend_q;
   logic        clr_we_q;
   logic [16:0] clr_addr_q;
   logic [15:0] clr_data_q;

   // Clear after the last replica (bottom-right of each block) has been read.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         clr_pend_q <= 1'b0;
         clr_we_q   <= 1'b0;
         clr_addr_q <= 17'd0;
         clr_data_q <= 16'd0;
      end else begin
         clr_pend_q <= w_rd_en && (hcount_in[SCALE_LOG-1:0] == '1)
                               && (vcount_in[SCALE_LOG-1:0] == '1);
         clr_we_q   <= clr_pend_q;
         if (clr_pend_q) begin
            clr_addr_q <= rd_addr_q;
            clr_data_q <= BG_COLOR;
         end
      end
   end

   assign clr_we_out   = clr_we_q;
   assign clr_addr_out = clr_addr_q;
   assign clr_data_out = clr_data_q;
`else
   logic w_unused_bg;
   assign w_unused_bg  = ^BG_COLOR;
   assign clr_we_out   = 1'b0;
   assign clr_addr_out = 17'd0;
   assign clr_data_out = 16'd0;
`endif

   assign rd_addr_out      = rd_addr_q;
   assign write_buffer_out = ~disp_q;
   assign render_start_out = render_start_q;
   assign overrun_out      = overrun_q;
   assign red_out          = red_q;
   assign green_out        = green_q;
   assign blue_out         = blue_q;
   assign hsync_out        = hs_q[3];
   assign vsync_out        = vs_q[3];
   assign active_draw_out  = act_q[3];

endmodule
`default_nettype wire
